// File: rtl/if_bus_if.sv
// if_bus_if: instruction-fetch to Wishbone master bridge.
// Runs one read cycle at a time for the fetch stage.
// It holds the fetched word while IF/ID is stalled.
// It aborts a cycle that gets no acknowledge within ACK_TIMEOUT cycles.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   stall[5:0]          pipeline stall vector (bit 1 holds IF/ID)
//   flush               exception flush, overrides every other request
//   cpu_ce_i            fetch enable
//   cpu_addr_i[31:0]    fetch address
//   cpu_data_o[31:0]    fetched instruction (combinational)
//   stallreq_o          stall request while a fetch is outstanding (combinational)
//   bus_err_o           one-cycle pulse after a fetch timeout
//   wb_*                Wishbone master read port
module if_bus_if #(
  parameter logic [7:0] ACK_TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  output logic        bus_err_o,
  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_data_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_data_i,
  input  logic        wb_ack_i
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY       = 2'd1,
    WAIT_STALL = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_d;
  logic [SW-1:0] sel_d;
  logic          stb_d, cyc_d, err_d;
  logic [DW-1:0] rd_buf_q, rd_buf_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Only stall[1] (IF/ID hold) matters to the fetch stage.
  logic unused_stall;
  assign unused_stall = ^{stall[5:2], stall[0]};

  // Read-only master.
  assign wb_data_o = DW'(0);
  assign wb_we_o   = 1'b0;

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wb_addr_o <= '0;
      wb_sel_o  <= '0;
      wb_stb_o  <= 1'b0;
      wb_cyc_o  <= 1'b0;
      rd_buf_q  <= '0;
      cnt_q     <= '0;
      bus_err_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      wb_addr_o <= addr_d;
      wb_sel_o  <= sel_d;
      wb_stb_o  <= stb_d;
      wb_cyc_o  <= cyc_d;
      rd_buf_q  <= rd_buf_d;
      cnt_q     <= cnt_d;
      bus_err_o <= err_d;
    end
  end

  // Next-state, next bus values and combinational CPU-side outputs.
  always_comb begin
    state_d    = state_q;
    addr_d     = wb_addr_o;
    sel_d      = wb_sel_o;
    stb_d      = wb_stb_o;
    cyc_d      = wb_cyc_o;
    rd_buf_d   = rd_buf_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    stallreq_o = 1'b0;
    cpu_data_o = DW'(0);

    case (state_q)
      IDLE: begin
        stallreq_o = cpu_ce_i;
        if (cpu_ce_i && !flush) begin
          addr_d  = cpu_addr_i;
          sel_d   = SW'(4'b1111);
          stb_d   = 1'b1;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        stallreq_o = ~wb_ack_i;
        if (wb_ack_i) cpu_data_o = wb_data_i;
        if (flush) begin
          // Flush discards the cycle even if it is being acknowledged now.
          addr_d   = '0;
          sel_d    = '0;
          stb_d    = 1'b0;
          cyc_d    = 1'b0;
          rd_buf_d = '0;
          cnt_d    = '0;
          state_d  = IDLE;
        end else if (wb_ack_i) begin
          addr_d   = '0;
          sel_d    = '0;
          stb_d    = 1'b0;
          cyc_d    = 1'b0;
          rd_buf_d = wb_data_i;
          cnt_d    = '0;
          state_d  = stall[1] ? WAIT_STALL : IDLE;
        end else if (cnt_q == CW'(ACK_TIMEOUT - 8'd1)) begin
          addr_d   = '0;
          sel_d    = '0;
          stb_d    = 1'b0;
          cyc_d    = 1'b0;
          rd_buf_d = '0;
          cnt_d    = '0;
          err_d    = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_STALL: begin
        cpu_data_o = rd_buf_q;
        if (flush) begin
          rd_buf_d = '0;
          state_d  = IDLE;
        end else if (!stall[1]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush forces a NOP and no stall request in every state.
    if (flush) begin
      stallreq_o = 1'b0;
      cpu_data_o = DW'(0);
    end
  end

endmodule

// File: tb/tb_if_bus_if.sv
module tb_if_bus_if;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush, cpu_ce_i, wb_ack_i;
  logic [31:0] cpu_addr_i, wb_data_i;
  logic [31:0] cpu_data_o, wb_addr_o, wb_data_o;
  logic        stallreq_o, bus_err_o, wb_we_o, wb_stb_o, wb_cyc_o;
  logic [3:0]  wb_sel_o;

  int checks = 0;
  int passes = 0;

  if_bus_if #(.ACK_TIMEOUT(8'(T))) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cpu_ce_i(cpu_ce_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_o(cpu_data_o), .stallreq_o(stallreq_o),
    .bus_err_o(bus_err_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  // Transaction-level reference: is a read outstanding, how long has it
  // waited, is a fetched word being held for a stalled IF/ID.
  bit          m_out, m_hold, m_err;
  int          m_age;
  logic [31:0] m_addr, m_buf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_out = 0; m_hold = 0; m_err = 0; m_age = 0; m_addr = '0; m_buf = '0;
  endtask

  task automatic model_check();
    logic [31:0] e_data;
    logic        e_sreq;
    if (flush)                  begin e_sreq = 0;         e_data = '0;        end
    else if (m_out)             begin e_sreq = !wb_ack_i; e_data = wb_ack_i ? wb_data_i : 32'h0; end
    else if (m_hold)            begin e_sreq = 0;         e_data = m_buf;     end
    else                        begin e_sreq = cpu_ce_i;  e_data = '0;        end
    chk("m_stb",   32'(wb_stb_o),   32'(m_out));
    chk("m_cyc",   32'(wb_cyc_o),   32'(m_out));
    chk("m_sel",   32'(wb_sel_o),   m_out ? 32'hF : 32'h0);
    chk("m_addr",  wb_addr_o,       m_out ? m_addr : 32'h0);
    chk("m_err",   32'(bus_err_o),  32'(m_err));
    chk("m_sreq",  32'(stallreq_o), 32'(e_sreq));
    chk("m_data",  cpu_data_o,      e_data);
    chk("m_we",    32'(wb_we_o),    32'h0);
    chk("m_wdat",  wb_data_o,       32'h0);
  endtask

  // Advance the model by one clock edge using the inputs applied this cycle.
  task automatic tick();
    @(posedge clk);
    m_err = 0;
    if (m_out) begin
      if (flush)                begin m_out = 0; m_buf = '0; end
      else if (wb_ack_i)        begin m_out = 0; m_buf = wb_data_i; m_hold = stall[1]; end
      else if (m_age == T - 1)  begin m_out = 0; m_buf = '0; m_err = 1; end
      else                      m_age++;
    end else if (m_hold) begin
      if (flush) begin m_hold = 0; m_buf = '0; end
      else if (!stall[1]) m_hold = 0;
    end else if (cpu_ce_i && !flush) begin
      m_out = 1; m_addr = cpu_addr_i; m_age = 0;
    end
  endtask

  task automatic drive(input logic ce, input logic fl, input logic [5:0] st,
                       input logic ack, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    cpu_ce_i = ce; flush = fl; stall = st; wb_ack_i = ack; cpu_addr_i = a; wb_data_i = d;
    #1;
  endtask

  typedef struct {
    logic        ce, fl;
    logic [5:0]  st;
    logic        ack;
    logic [31:0] a, d;
    logic        e_stb;
    logic [31:0] e_addr;
    logic        e_sreq;
    logic [31:0] e_data;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ce, input logic fl, input logic [5:0] st, input logic ack,
                     input logic [31:0] a, input logic [31:0] d, input logic e_stb,
                     input logic [31:0] e_addr, input logic e_sreq, input logic [31:0] e_data,
                     input logic e_err);
    vec_t v;
    v.ce = ce; v.fl = fl; v.st = st; v.ack = ack; v.a = a; v.d = d;
    v.e_stb = e_stb; v.e_addr = e_addr; v.e_sreq = e_sreq; v.e_data = e_data; v.e_err = e_err;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1; stall = '0; flush = 0; cpu_ce_i = 0; wb_ack_i = 0;
    cpu_addr_i = '0; wb_data_i = '0;
    model_reset();
    #1;
    chk("rst_stb",  32'(wb_stb_o),   32'h0);
    chk("rst_cyc",  32'(wb_cyc_o),   32'h0);
    chk("rst_addr", wb_addr_o,       32'h0);
    chk("rst_sel",  32'(wb_sel_o),   32'h0);
    chk("rst_err",  32'(bus_err_o),  32'h0);
    chk("rst_data", cpu_data_o,      32'h0);
    chk("rst_sreq", 32'(stallreq_o), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    //   ce fl stall     ack addr          rdata          stb addr          sreq data           err
    // basic fetch, ack on third BUSY cycle
    add(1, 0, 6'd0, 0, 32'h0000_0100, 32'h0,          0, 32'h0,          1, 32'h0,          0);
    add(1, 0, 6'd0, 0, 32'h0000_0100, 32'h0,          1, 32'h0000_0100,  1, 32'h0,          0);
    add(1, 0, 6'd0, 0, 32'h0000_0100, 32'h0,          1, 32'h0000_0100,  1, 32'h0,          0);
    add(1, 0, 6'd0, 1, 32'h0000_0100, 32'h3401_1100,  1, 32'h0000_0100,  0, 32'h3401_1100,  0);
    add(0, 0, 6'd0, 0, 32'h0,         32'h0,          0, 32'h0,          0, 32'h0,          0);
    // ack while IF/ID stalled: word held until stall[1] drops
    add(1, 0, 6'd0, 0, 32'h0000_0200, 32'h0,          0, 32'h0,          1, 32'h0,          0);
    add(0, 0, 6'd3, 1, 32'h0,         32'hABCD_0001,  1, 32'h0000_0200,  0, 32'hABCD_0001,  0);
    add(0, 0, 6'd3, 0, 32'h0,         32'h0,          0, 32'h0,          0, 32'hABCD_0001,  0);
    add(1, 0, 6'd3, 0, 32'h0,         32'h0,          0, 32'h0,          0, 32'hABCD_0001,  0);
    add(0, 0, 6'd0, 0, 32'h0,         32'h0,          0, 32'h0,          0, 32'hABCD_0001,  0);
    add(0, 0, 6'd0, 0, 32'h0,         32'h0,          0, 32'h0,          0, 32'h0,          0);
    // flush beats a same-cycle ack
    add(1, 0, 6'd0, 0, 32'h0000_0300, 32'h0,          0, 32'h0,          1, 32'h0,          0);
    add(1, 1, 6'd0, 1, 32'h0000_0300, 32'hDEAD_BEEF,  1, 32'h0000_0300,  0, 32'h0,          0);
    add(0, 0, 6'd0, 0, 32'h0,         32'h0,          0, 32'h0,          0, 32'h0,          0);
    // timeout after exactly T BUSY cycles; cpu_addr_i moves, bus address must not
    add(1, 0, 6'd0, 0, 32'h0000_0400, 32'h0,          0, 32'h0,          1, 32'h0,          0);
    add(0, 0, 6'd0, 0, 32'h0000_0404, 32'h0,          1, 32'h0000_0400,  1, 32'h0,          0);
    add(0, 0, 6'd0, 0, 32'h0000_0408, 32'h0,          1, 32'h0000_0400,  1, 32'h0,          0);
    add(0, 0, 6'd0, 0, 32'h0000_040C, 32'h0,          1, 32'h0000_0400,  1, 32'h0,          0);
    add(0, 0, 6'd0, 0, 32'h0000_0410, 32'h0,          1, 32'h0000_0400,  1, 32'h0,          0);
    add(0, 0, 6'd0, 0, 32'h0,         32'h0,          0, 32'h0,          0, 32'h0,          1);
    add(0, 0, 6'd0, 0, 32'h0,         32'h0,          0, 32'h0,          0, 32'h0,          0);

    foreach (vecs[i]) begin
      drive(vecs[i].ce, vecs[i].fl, vecs[i].st, vecs[i].ack, vecs[i].a, vecs[i].d);
      chk($sformatf("v%0d_stb", i),  32'(wb_stb_o),   32'(vecs[i].e_stb));
      chk($sformatf("v%0d_cyc", i),  32'(wb_cyc_o),   32'(vecs[i].e_stb));
      chk($sformatf("v%0d_addr", i), wb_addr_o,       vecs[i].e_addr);
      chk($sformatf("v%0d_sreq", i), 32'(stallreq_o), 32'(vecs[i].e_sreq));
      chk($sformatf("v%0d_data", i), cpu_data_o,      vecs[i].e_data);
      chk($sformatf("v%0d_err", i),  32'(bus_err_o),  32'(vecs[i].e_err));
      model_check();
      tick();
    end

    // Asynchronous reset in the middle of a bus cycle, then a late ack.
    drive(1, 0, 6'd0, 0, 32'h0000_0500, 32'h0);
    model_check();
    tick();
    #2;
    chk("ar_busy_stb", 32'(wb_stb_o), 32'h1);
    cpu_ce_i = 0; rst = 1'b1;
    #1;
    chk("ar_stb",  32'(wb_stb_o),   32'h0);
    chk("ar_cyc",  32'(wb_cyc_o),   32'h0);
    chk("ar_addr", wb_addr_o,       32'h0);
    chk("ar_sel",  32'(wb_sel_o),   32'h0);
    chk("ar_sreq", 32'(stallreq_o), 32'h0);
    model_reset();
    #1 rst = 1'b0;
    drive(0, 0, 6'd0, 1, 32'h0, 32'hCAFE_F00D);
    chk("late_ack_data", cpu_data_o, 32'h0);
    model_check();
    tick();
    drive(0, 0, 6'd0, 0, 32'h0, 32'h0);
    chk("late_ack_stb", 32'(wb_stb_o), 32'h0);
    model_check();
    tick();

    // Randomized traffic against the reference.
    for (int n = 0; n < 600; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
            6'($urandom), 1'($urandom_range(0, 2) == 0), $urandom, $urandom);
      model_check();
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
